prescaler_selector: RTL and testbench
=====================================

Name: prescaler_selector

Overview:
- Bit-level waveform encoder for a WS2812-style single-wire LED stripe.
- Each data bit becomes a high pulse followed by a low pulse. Bit 0 is short-high/long-low; bit 1 is long-high/short-low.
- Pulse durations are measured by external short/long timers (prescalers), which this block selects via wait/measured handshakes.
- Sits between the bit shifter (upstream) and the stripe pin. After the last bit it holds the line low until the external reset/latch timer finishes.

Parameters:
- None. State encoding is local.

Ports:
- clk  input  1  system clock, rising-edge
- rstn  input  1  asynchronous active-low reset
- bit_to_transmit  input  1  current data bit from shifter; valid at the end of the LOAD cycle
- all_bits_shifted  input  1  shifter has no more bits; sampled at the end of LOAD
- reset_finish  input  1  external reset/latch-time timer expired
- new_bit_rqst  output  1  request/consume strobe to shifter; high exactly during LOAD
- l_time_wait  output  1  enables the long-time timer; high while a long phase is in progress
- l_time_measured  input  1  long-time timer expired (level, at least 1 cycle)
- s_time_wait  output  1  enables the short-time timer; high while a short phase is in progress
- s_time_measured  input  1  short-time timer expired (level, at least 1 cycle)
- led_stripe_pin  output  1  serial data line to the LED stripe

Behaviour:
- Reset is asynchronous and active-low. During reset: state=IDLE, and all outputs (new_bit_rqst, l_time_wait, s_time_wait, led_stripe_pin) are 0. The bit register cur_bit=0.
- All outputs are registered Moore decodes of the state flops plus cur_bit. There is no combinational path from inputs to outputs.
- IDLE: all outputs 0. Goes to LOAD unconditionally on the next edge.
- LOAD: new_bit_rqst=1, pin=0, both waits 0. Lasts exactly 1 cycle.
  - At the edge ending LOAD, if all_bits_shifted=1, go to LATCH.
  - Otherwise capture cur_bit<=bit_to_transmit and go to HIGH.
  - The upstream block updates bit_to_transmit during the LOAD cycle in response to the request.
- HIGH: pin=1.
  - cur_bit=0: s_time_wait=1, l_time_wait=0. Leave to LOW on an edge with s_time_measured=1.
  - cur_bit=1: l_time_wait=1, s_time_wait=0. Leave to LOW on an edge with l_time_measured=1.
  - The non-selected measured input is ignored.
- LOW: pin=0.
  - cur_bit=0: l_time_wait=1. Exit on l_time_measured=1.
  - cur_bit=1: s_time_wait=1. Exit on s_time_measured=1.
  - Exit goes to LOAD.
- LATCH: pin=0, both waits 0, new_bit_rqst=0. Goes to LOAD on an edge with reset_finish=1.
- Handshake rules:
  - Each *_wait is a level that stays high until the matching measured input is seen.
  - The external timer counts while wait=1 and clears when wait=0.
  - A measured pulse longer than 1 cycle is harmless: the next phase always waits on a different timer, or passes through LOAD first.
- Waits are mutually exclusive; never both high.
- Simultaneous s/l_time_measured: only the one matching the current phase acts.
- Measured inputs asserted in IDLE, LOAD or LATCH are ignored.
- rstn asserted mid-phase: immediate return to IDLE, pin forced 0.
- A phase has a minimum duration of 1 cycle, even if measured is already high on entry.

Decomposition:
- Shared package holds the state typedef (IDLE, LOAD, HIGH, LOW, LATCH). It is shared with the stripe controller for debug visibility.
- No sub-module. The timers/prescalers live outside this block. A single FSM module is natural.

Test Plan:
- Reset: rstn=0 -> all outputs 0. Release -> 1 cycle IDLE, then new_bit_rqst=1 for exactly 1 cycle.
- Bit 0: bit_to_transmit=0 at LOAD.
  - Expect pin=1 and s_time_wait=1 until s_time_measured is pulsed 1 cycle (after 3 cycles of waiting).
  - Then pin=0 and l_time_wait=1 until l_time_measured is pulsed (after 9 cycles).
  - Then new_bit_rqst=1.
- Bit 1: shifter drives 1 during LOAD.
  - Expect pin=1 with l_time_wait=1 until l_time_measured.
  - Then pin=0 with s_time_wait=1 until s_time_measured.
  - Then LOAD.
- Wrong-timer immunity: pulse l_time_measured during a bit-0 HIGH phase -> no transition, pin stays 1.
- End of frame: all_bits_shifted=1 at LOAD.
  - Expect pin=0, waits=0 indefinitely.
  - reset_finish=1 -> next cycle new_bit_rqst=1.
- Mid-phase reset: assert rstn=0 during a HIGH phase -> pin=0 asynchronously and all waits 0.

Source files
------------

// File: rtl/prescaler_selector_pkg.sv
// Shared definitions for the WS2812-style bit waveform encoder.
//
// The state type is exported so the stripe controller can expose the encoder
// phase on its debug bus without duplicating the encoding.
package prescaler_selector_pkg;

    // Encoder phases:
    //   StIdle  - post-reset filler, lasts one cycle
    //   StLoad  - request/consume one bit from the shifter (one cycle)
    //   StHigh  - line driven high, waiting on the bit's high-time timer
    //   StLow   - line driven low, waiting on the bit's low-time timer
    //   StLatch - frame finished, line held low until the latch timer expires
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StHigh  = 3'd2,
        StLow   = 3'd3,
        StLatch = 3'd4
    } state_e;

    // A bit is encoded as a short+long pair: a 0 is short-high/long-low and a 1 is
    // long-high/short-low. Returns 1 when the given pulse phase uses the long timer.
    function automatic logic phase_is_long(input state_e state, input logic cur_bit);
        logic is_long;
        is_long = 1'b0;
        if (state == StHigh) begin
            is_long = cur_bit;
        end else if (state == StLow) begin
            is_long = ~cur_bit;
        end
        return is_long;
    endfunction

    // True for the two phases in which one of the pulse timers is running.
    function automatic logic phase_is_pulse(input state_e state);
        return (state == StHigh) || (state == StLow);
    endfunction

endpackage

// File: rtl/prescaler_selector.sv
// Bit-level waveform encoder for a single-wire WS2812-style LED stripe.
//
// Each data bit taken from the upstream shifter becomes a high pulse followed
// by a low pulse whose lengths are measured by two external timers (short and
// long). After the last bit the line is held low until the external latch
// timer reports completion, then the next frame is requested.
//
// Ports:
//   clk              - system clock, rising edge
//   rstn             - asynchronous active-low reset
//   bit_to_transmit  - current data bit from the shifter, captured at the end of LOAD
//   all_bits_shifted - shifter is empty, sampled at the end of LOAD
//   reset_finish     - external latch/reset timer expired
//   new_bit_rqst     - request/consume strobe to the shifter, high during LOAD
//   l_time_wait      - enables the long-time timer during a long phase
//   l_time_measured  - long-time timer expired
//   s_time_wait      - enables the short-time timer during a short phase
//   s_time_measured  - short-time timer expired
//   led_stripe_pin   - serial data line to the stripe
//
// All outputs are decoded only from the state and captured-bit flops, so no
// input ever reaches an output combinationally.
module prescaler_selector
    import prescaler_selector_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic bit_to_transmit,
    input  logic all_bits_shifted,
    input  logic reset_finish,
    output logic new_bit_rqst,
    output logic l_time_wait,
    input  logic l_time_measured,
    output logic s_time_wait,
    input  logic s_time_measured,
    output logic led_stripe_pin
);

    state_e state_q, state_d;
    logic   cur_bit_q, cur_bit_d;

    // The measured input that terminates the current phase. Only the timer
    // belonging to the phase is looked at, so the other one is ignored even
    // when both are asserted together or a previous pulse lingers.
    logic phase_long;
    logic phase_done;

    always_comb begin
        phase_long = phase_is_long(state_q, cur_bit_q);
        phase_done = phase_long ? l_time_measured : s_time_measured;
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cur_bit_d = cur_bit_q;
        unique case (state_q)
            StIdle: begin
                state_d = StLoad;
            end
            StLoad: begin
                if (all_bits_shifted) begin
                    state_d = StLatch;
                end else begin
                    cur_bit_d = bit_to_transmit;
                    state_d   = StHigh;
                end
            end
            StHigh: begin
                if (phase_done) begin
                    state_d = StLow;
                end
            end
            StLow: begin
                if (phase_done) begin
                    state_d = StLoad;
                end
            end
            StLatch: begin
                if (reset_finish) begin
                    state_d = StLoad;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cur_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_bit_q <= cur_bit_d;
        end
    end

    // Moore output decode. The waits are mutually exclusive by construction:
    // a pulse phase enables exactly one timer, every other phase enables none.
    always_comb begin
        new_bit_rqst   = 1'b0;
        led_stripe_pin = 1'b0;
        l_time_wait    = 1'b0;
        s_time_wait    = 1'b0;
        if (state_q == StLoad) begin
            new_bit_rqst = 1'b1;
        end
        if (state_q == StHigh) begin
            led_stripe_pin = 1'b1;
        end
        if (phase_is_pulse(state_q)) begin
            l_time_wait = phase_long;
            s_time_wait = ~phase_long;
        end
    end

endmodule

// File: tb/tb_prescaler_selector.sv
// Self-checking bench for prescaler_selector. Inputs are driven and outputs are
// sampled on the falling clock edge. Expected outputs come from the waveform
// rule of the line code: each bit is one request cycle, then a high phase and
// a low phase, each timed by the short or long timer depending on the bit.
module tb_prescaler_selector;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic bit_to_transmit = 1'b0;
    logic all_bits_shifted = 1'b0;
    logic reset_finish = 1'b0;
    logic new_bit_rqst;
    logic l_time_wait;
    logic l_time_measured = 1'b0;
    logic s_time_wait;
    logic s_time_measured = 1'b0;
    logic led_stripe_pin;

    int n_cmp = 0;
    int n_err = 0;

    prescaler_selector dut (
        .clk             (clk),
        .rstn            (rstn),
        .bit_to_transmit (bit_to_transmit),
        .all_bits_shifted(all_bits_shifted),
        .reset_finish    (reset_finish),
        .new_bit_rqst    (new_bit_rqst),
        .l_time_wait     (l_time_wait),
        .l_time_measured (l_time_measured),
        .s_time_wait     (s_time_wait),
        .s_time_measured (s_time_measured),
        .led_stripe_pin  (led_stripe_pin)
    );

    always #5 clk = ~clk;

    // Observed output vector: {new_bit_rqst, l_time_wait, s_time_wait, pin}
    logic [3:0] obs;
    assign obs = {new_bit_rqst, l_time_wait, s_time_wait, led_stripe_pin};

    localparam logic [3:0] ExpQuiet = 4'b0000;
    localparam logic [3:0] ExpLoad  = 4'b1000;

    // Expected outputs during a pulse phase of data bit b. Bit 1 has a long
    // high part, bit 0 a long low part; the other part is short.
    function automatic logic [3:0] exp_pulse(input logic high_part, input logic b);
        logic use_long;
        use_long = high_part ? b : ~b;
        return {1'b0, use_long, ~use_long, high_part};
    endfunction

    // Drives the two timer outputs: the phase's own timer gets 'fire', the
    // other one gets noise that must be ignored.
    task automatic drive_timers(input logic use_long, input logic fire);
        if (use_long) begin
            l_time_measured = fire;
            s_time_measured = 1'($urandom_range(0, 1));
        end else begin
            s_time_measured = fire;
            l_time_measured = 1'($urandom_range(0, 1));
        end
    endtask

    // Ends at a falling edge with the DUT in LOAD (checked).
    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== ExpQuiet) $display("FAIL reset_hold: got %b expected %b", obs, ExpQuiet);
        if (obs !== ExpQuiet) n_err++;
        rstn = 1'b1;
        #1;
        n_cmp++;
        if (obs !== ExpQuiet) begin
            $display("FAIL reset_release_idle: got %b expected %b", obs, ExpQuiet);
            n_err++;
        end
        @(negedge clk);
        n_cmp++;
        if (obs !== ExpLoad) begin
            $display("FAIL reset_first_load: got %b expected %b", obs, ExpLoad);
            n_err++;
        end
    endtask

    // Bit 0: short high (3 waiting cycles), long low (9 waiting cycles).
    task automatic test_bit0();
        bit_to_transmit  = 1'b0;
        all_bits_shifted = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            bit_to_transmit = 1'b1;
            n_cmp++;
            if (obs !== 4'b0011) begin
                $display("FAIL bit0_high[%0d]: got %b expected %b", i, obs, 4'b0011);
                n_err++;
            end
            s_time_measured = (i == 3);
        end
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            s_time_measured = 1'b0;
            n_cmp++;
            if (obs !== 4'b0100) begin
                $display("FAIL bit0_low[%0d]: got %b expected %b", i, obs, 4'b0100);
                n_err++;
            end
            l_time_measured = (i == 9);
        end
        @(negedge clk);
        l_time_measured = 1'b0;
        n_cmp++;
        if (obs !== ExpLoad) begin
            $display("FAIL bit0_next_load: got %b expected %b", obs, ExpLoad);
            n_err++;
        end
    endtask

    // Bit 1: long high, short low; the data input changes after LOAD.
    task automatic test_bit1();
        bit_to_transmit  = 1'b1;
        all_bits_shifted = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            bit_to_transmit = 1'b0;
            n_cmp++;
            if (obs !== 4'b0101) begin
                $display("FAIL bit1_high[%0d]: got %b expected %b", i, obs, 4'b0101);
                n_err++;
            end
            l_time_measured = (i == 6);
        end
        for (int i = 0; i <= 2; i++) begin
            @(negedge clk);
            l_time_measured = 1'b0;
            n_cmp++;
            if (obs !== 4'b0010) begin
                $display("FAIL bit1_low[%0d]: got %b expected %b", i, obs, 4'b0010);
                n_err++;
            end
            s_time_measured = (i == 2);
        end
        @(negedge clk);
        s_time_measured = 1'b0;
        n_cmp++;
        if (obs !== ExpLoad) begin
            $display("FAIL bit1_next_load: got %b expected %b", obs, ExpLoad);
            n_err++;
        end
    endtask

    // Bit 0 with the long timer pulsing during the high part, both timers
    // together at the exit, and the short timer lingering into the low part.
    task automatic test_wrong_timer();
        bit_to_transmit = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== 4'b0011) begin
                $display("FAIL wrong_timer_high[%0d]: got %b expected %b", i, obs, 4'b0011);
                n_err++;
            end
            l_time_measured = (i >= 1);
            s_time_measured = (i == 5);
        end
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== 4'b0100) begin
                $display("FAIL wrong_timer_low[%0d]: got %b expected %b", i, obs, 4'b0100);
                n_err++;
            end
            s_time_measured = 1'b1;
            l_time_measured = (i == 3);
        end
        @(negedge clk);
        s_time_measured = 1'b0;
        l_time_measured = 1'b0;
        n_cmp++;
        if (obs !== ExpLoad) begin
            $display("FAIL wrong_timer_next_load: got %b expected %b", obs, ExpLoad);
            n_err++;
        end
    endtask

    // Shifter empty at LOAD: line stays low with no timers until reset_finish.
    task automatic test_end_of_frame();
        all_bits_shifted = 1'b1;
        bit_to_transmit  = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            all_bits_shifted = 1'b0;
            s_time_measured  = 1'($urandom_range(0, 1));
            l_time_measured  = 1'($urandom_range(0, 1));
            n_cmp++;
            if (obs !== ExpQuiet) begin
                $display("FAIL latch_hold[%0d]: got %b expected %b", i, obs, ExpQuiet);
                n_err++;
            end
            reset_finish = (i == 7);
        end
        @(negedge clk);
        reset_finish    = 1'b0;
        s_time_measured = 1'b0;
        l_time_measured = 1'b0;
        n_cmp++;
        if (obs !== ExpLoad) begin
            $display("FAIL latch_next_load: got %b expected %b", obs, ExpLoad);
            n_err++;
        end
    endtask

    // Reset asserted between clock edges during a high phase.
    task automatic test_mid_reset();
        bit_to_transmit = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs !== 4'b0011) begin
            $display("FAIL mid_reset_pre: got %b expected %b", obs, 4'b0011);
            n_err++;
        end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if (obs !== ExpQuiet) begin
            $display("FAIL mid_reset_async: got %b expected %b", obs, ExpQuiet);
            n_err++;
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_cmp++;
        if (obs !== ExpQuiet) begin
            $display("FAIL mid_reset_idle: got %b expected %b", obs, ExpQuiet);
            n_err++;
        end
        @(negedge clk);
        n_cmp++;
        if (obs !== ExpLoad) begin
            $display("FAIL mid_reset_load: got %b expected %b", obs, ExpLoad);
            n_err++;
        end
    endtask

    // Random frames: random bits, random phase lengths (including zero extra
    // wait), random noise on the unused timer and on ignored inputs.
    task automatic test_random_frames();
        for (int f = 0; f < 8; f++) begin
            int nbits;
            nbits = int'($urandom_range(1, 6));
            for (int k = 0; k < nbits; k++) begin
                logic b;
                int   hi_n;
                int   lo_n;
                b    = 1'($urandom_range(0, 1));
                hi_n = int'($urandom_range(0, 5));
                lo_n = int'($urandom_range(0, 5));
                bit_to_transmit  = b;
                all_bits_shifted = 1'b0;
                reset_finish     = 1'($urandom_range(0, 1));
                for (int i = 0; i <= hi_n; i++) begin
                    @(negedge clk);
                    bit_to_transmit = 1'($urandom_range(0, 1));
                    reset_finish    = 1'($urandom_range(0, 1));
                    n_cmp++;
                    if (obs !== exp_pulse(1'b1, b)) begin
                        $display("FAIL rand_high f%0d b%0d[%0d]: got %b expected %b",
                                 f, k, i, obs, exp_pulse(1'b1, b));
                        n_err++;
                    end
                    drive_timers(b, i == hi_n);
                end
                for (int i = 0; i <= lo_n; i++) begin
                    @(negedge clk);
                    bit_to_transmit = 1'($urandom_range(0, 1));
                    n_cmp++;
                    if (obs !== exp_pulse(1'b0, b)) begin
                        $display("FAIL rand_low f%0d b%0d[%0d]: got %b expected %b",
                                 f, k, i, obs, exp_pulse(1'b0, b));
                        n_err++;
                    end
                    drive_timers(~b, i == lo_n);
                end
                @(negedge clk);
                n_cmp++;
                if (obs !== ExpLoad) begin
                    $display("FAIL rand_load f%0d b%0d: got %b expected %b", f, k, obs, ExpLoad);
                    n_err++;
                end
            end
            // End of frame with a random latch time.
            begin
                int m;
                m = int'($urandom_range(0, 6));
                all_bits_shifted = 1'b1;
                reset_finish     = 1'b0;
                for (int i = 0; i <= m; i++) begin
                    @(negedge clk);
                    all_bits_shifted = 1'($urandom_range(0, 1));
                    bit_to_transmit  = 1'($urandom_range(0, 1));
                    s_time_measured  = 1'($urandom_range(0, 1));
                    l_time_measured  = 1'($urandom_range(0, 1));
                    n_cmp++;
                    if (obs !== ExpQuiet) begin
                        $display("FAIL rand_latch f%0d[%0d]: got %b expected %b",
                                 f, i, obs, ExpQuiet);
                        n_err++;
                    end
                    reset_finish = (i == m);
                end
                @(negedge clk);
                reset_finish = 1'b0;
                n_cmp++;
                if (obs !== ExpLoad) begin
                    $display("FAIL rand_frame_load f%0d: got %b expected %b", f, obs, ExpLoad);
                    n_err++;
                end
            end
        end
        s_time_measured  = 1'b0;
        l_time_measured  = 1'b0;
        all_bits_shifted = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bit0();
        test_bit1();
        test_wrong_timer();
        test_end_of_frame();
        test_mid_reset();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
